// File: rtl/great_adder_arbiter_pkg.sv
// great_adder_pkg: shared state type and sizing helper for the adder arbiter
package great_adder_pkg;
  typedef enum logic {IDLE, STREAM} arb_state_t;
  function automatic int num_packets(input int bits, input int w);
    return bits / w;
  endfunction
endpackage

// File: rtl/great_adder_arbiter_if.sv
// great_adder_arbiter_if: requester, adder and result signals of the adder arbiter
interface great_adder_arbiter_if #(parameter int N = 4, parameter int W = 32);
  localparam int OW = $clog2(N);
  logic [N-1:0] req_in, valid_in, ready_out;
  logic [N*W-1:0] a_in, b_in;
  logic [W-1:0] adder_a_out, adder_b_out, adder_sum_in, sum_out;
  logic adder_valid_out, adder_carry_out, adder_rst_out, adder_cout_in, adder_final_in;
  logic sum_valid_out, sum_last_out, sum_carry_out, busy_out, error_out;
  logic [OW-1:0] sum_owner_out;
  modport slave (
    input req_in, valid_in, a_in, b_in, adder_sum_in, adder_cout_in, adder_final_in,
    output ready_out, adder_a_out, adder_b_out, adder_valid_out, adder_carry_out, adder_rst_out,
    output sum_out, sum_valid_out, sum_last_out, sum_carry_out, sum_owner_out, busy_out, error_out
  );
  modport master (
    output req_in, valid_in, a_in, b_in, adder_sum_in, adder_cout_in, adder_final_in,
    input ready_out, adder_a_out, adder_b_out, adder_valid_out, adder_carry_out, adder_rst_out,
    input sum_out, sum_valid_out, sum_last_out, sum_carry_out, sum_owner_out, busy_out, error_out
  );
endinterface

// File: rtl/great_adder_arbiter_rr_pick.sv
// rr_pick: combinational search for the first request at or after a pointer, wrapping
module rr_pick #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          found_o,
  output logic [PW-1:0] idx_o
);
  logic [N-1:0] rot;
  logic [PW:0] sum_k;
  assign rot = N'({req_i, req_i} >> ptr_i);
  assign found_o = |req_i;
  // scan from the far end so the nearest request after the pointer wins
  always_comb begin
    idx_o = '0;
    sum_k = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum_k = {1'b0, ptr_i} + (PW+1)'(k);
        idx_o = PW'(sum_k >= (PW+1)'(N) ? sum_k - (PW+1)'(N) : sum_k);
      end
    end
  end
endmodule

// File: rtl/great_adder_arbiter.sv
// great_adder_arbiter: round-robin owner of one shared streaming big-number adder
// Locks a grant for a whole operation and returns registered, owner-tagged sum packets.
module great_adder_arbiter
  import great_adder_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 2048
) (
  input logic clk_in,
  input logic rst_n_in,
  great_adder_arbiter_if.slave bus
);
  localparam int N  = NUM_REQ;
  localparam int W  = REGISTER_SIZE;
  localparam int NP = num_packets(BITS_IN_NUM, W);
  localparam int OW = $clog2(N);
  localparam int CW = $clog2(NP) + 1;
  arb_state_t state_q, state_d;
  logic [OW-1:0] ptr_q, ptr_d, owner_q, owner_d, pick, sum_owner_q, sum_owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] sum_q, sum_d;
  logic sum_valid_q, sum_valid_d, sum_last_q, sum_last_d, sum_carry_q, sum_carry_d;
  logic error_q, error_d;
  logic found, stream, accept, last;
  rr_pick #(.N(N)) u_pick (.req_i(bus.req_in), .ptr_i(ptr_q), .found_o(found), .idx_o(pick));
  assign stream = state_q == STREAM;
  assign accept = stream && bus.valid_in[owner_q];
  assign last   = cnt_q == CW'(NP - 1);
  assign bus.ready_out       = stream ? N'(1) << owner_q : '0;
  assign bus.adder_a_out     = stream ? bus.a_in[owner_q*W +: W] : '0;
  assign bus.adder_b_out     = stream ? bus.b_in[owner_q*W +: W] : '0;
  assign bus.adder_valid_out = accept;
  assign bus.adder_carry_out = 1'b0;
  // holding the adder in reset while idle re-aligns its packet counter between operations
  assign bus.adder_rst_out   = !stream;
  assign bus.busy_out        = stream;
  assign bus.sum_out         = sum_q;
  assign bus.sum_valid_out   = sum_valid_q;
  assign bus.sum_last_out    = sum_last_q;
  assign bus.sum_carry_out   = sum_carry_q;
  assign bus.sum_owner_out   = sum_owner_q;
  assign bus.error_out       = error_q;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (!stream && found) begin
      state_d = STREAM;
      owner_d = pick;
    end
    if (accept) begin
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      state_d = last ? IDLE : STREAM;
      ptr_d   = last ? (owner_q == OW'(N - 1) ? '0 : owner_q + 1'b1) : ptr_q;
    end
    sum_valid_d = accept;
    sum_d       = accept ? bus.adder_sum_in : '0;
    sum_owner_d = accept ? owner_q : '0;
    sum_last_d  = accept && last;
    sum_carry_d = accept && last && bus.adder_cout_in;
    error_d     = error_q || (accept && (bus.adder_final_in != last));
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      sum_last_q  <= 1'b0;
      sum_carry_q <= 1'b0;
      sum_owner_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      sum_last_q  <= sum_last_d;
      sum_carry_q <= sum_carry_d;
      sum_owner_q <= sum_owner_d;
      error_q     <= error_d;
    end
  end
endmodule

// File: tb/tb_great_adder_arbiter.sv
// tb_great_adder_arbiter: random requesters against a cycle-level behavioural model of the arbiter
module tb_great_adder_arbiter;
  localparam int N = 4, W = 32, BITS = 128, NP = BITS / W;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  great_adder_arbiter_if #(.N(N), .W(W)) bus ();
  great_adder_arbiter #(.NUM_REQ(N), .REGISTER_SIZE(W), .BITS_IN_NUM(BITS)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .bus(bus));
  // stand-in streaming adder: internal carry chain, packet counter, final flag
  logic ad_c_q = 1'b0, force_final = 1'b0;
  int ad_n_q = 0;
  logic [W:0] ad_full;
  assign ad_full = {1'b0, bus.adder_a_out} + {1'b0, bus.adder_b_out} + (W+1)'(ad_c_q);
  assign bus.adder_sum_in   = ad_full[W-1:0];
  assign bus.adder_cout_in  = ad_full[W];
  assign bus.adder_final_in = (ad_n_q == NP - 1) || force_final;
  always @(posedge clk) begin
    if (bus.adder_rst_out) begin
      ad_c_q <= 1'b0;
      ad_n_q <= 0;
    end else if (bus.adder_valid_out) begin
      ad_c_q <= ad_full[W];
      ad_n_q <= ad_n_q == NP - 1 ? 0 : ad_n_q + 1;
    end
  end
  // requester side: each requester streams packet bi[i] of its current operands
  logic [BITS-1:0] opa [N], opb [N];
  int bi [N];
  logic [N-1:0] req = '0, vld = '1;
  assign bus.req_in   = req;
  assign bus.valid_in = vld;
  always_comb begin
    bus.a_in = '0;
    bus.b_in = '0;
    for (int i = 0; i < N; i++) begin
      bus.a_in[i*W +: W] = opa[i][bi[i]*W +: W];
      bus.b_in[i*W +: W] = opb[i][bi[i]*W +: W];
    end
  end
  int n_chk = 0, n_pass = 0;
  logic m_idle = 1'b1, err_m = 1'b0, stall_rand = 1'b0;
  int m_owner = 0, ptr_m = 0, hold = 0, ops_done = 0, busy_seen = 0, sums_seen = 0;
  logic pend_v = 1'b0, pend_last = 1'b0, pend_carry = 1'b0;
  logic [W-1:0] pend_sum = '0;
  int pend_own = 0;
  int owners [$];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic int rr_ref(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction
  task automatic regen(input int i);
    for (int k = 0; k < NP; k++) begin
      opa[i][k*W +: W] = $urandom;
      opb[i][k*W +: W] = $urandom;
    end
  endtask
  task automatic step();
    logic acc, err_n, grant;
    logic [BITS:0] full;
    logic [N-1:0] er;
    logic [W-1:0] ea;
    int k, g;
    @(negedge clk);
    chk("sum_valid", 64'(bus.sum_valid_out), 64'(pend_v));
    if (pend_v) begin
      chk("sum", 64'(bus.sum_out), 64'(pend_sum));
      chk("sum_owner", 64'(bus.sum_owner_out), 64'(pend_own));
      chk("sum_last", 64'(bus.sum_last_out), 64'(pend_last));
      chk("sum_carry", 64'(bus.sum_carry_out), 64'(pend_carry));
    end
    if (bus.sum_valid_out) sums_seen++;
    if (bus.sum_valid_out && bus.sum_last_out) owners.push_back(int'(bus.sum_owner_out));
    if (bus.busy_out) busy_seen++;
    er = m_idle ? '0 : N'(1) << m_owner;
    ea = m_idle ? '0 : opa[m_owner][bi[m_owner]*W +: W];
    acc = !m_idle && vld[m_owner];
    chk("ready", 64'(bus.ready_out), 64'(er));
    chk("busy", 64'(bus.busy_out), 64'(!m_idle));
    chk("adder_rst", 64'(bus.adder_rst_out), 64'(m_idle));
    chk("adder_valid", 64'(bus.adder_valid_out), 64'(acc));
    chk("adder_a", 64'(bus.adder_a_out), 64'(ea));
    chk("adder_carry", 64'(bus.adder_carry_out), 64'(0));
    chk("error", 64'(bus.error_out), 64'(err_m));
    k = bi[m_owner];
    full = {1'b0, opa[m_owner]} + {1'b0, opb[m_owner]};
    pend_v = acc;
    pend_sum = full[k*W +: W];
    pend_own = m_owner;
    pend_last = k == NP - 1;
    pend_carry = pend_last && full[BITS];
    err_n = err_m || (acc && force_final && k != NP - 1);
    grant = m_idle && |req;
    g = rr_ref(req, ptr_m);
    @(posedge clk);
    #1;
    err_m = err_n;
    if (grant) begin
      m_idle = 1'b0;
      m_owner = g;
    end else if (acc) begin
      bi[m_owner]++;
      if (bi[m_owner] == NP) begin
        bi[m_owner] = 0;
        m_idle = 1'b1;
        ptr_m = (m_owner + 1) % N;
        regen(m_owner);
        ops_done++;
      end
    end
    for (int i = 0; i < N; i++) vld[i] = stall_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (hold > 0) begin
      vld = '0;
      hold--;
    end
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 60 && !m_idle; i++) step();
    chk("idle_timeout", 64'(m_idle), 64'(1));
    step();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(bus.busy_out), 64'(0));
    chk("rst_ready", 64'(bus.ready_out), 64'(0));
    chk("rst_sum_valid", 64'(bus.sum_valid_out), 64'(0));
    chk("rst_sum_last", 64'(bus.sum_last_out), 64'(0));
    chk("rst_adder_rst", 64'(bus.adder_rst_out), 64'(1));
    chk("rst_adder_a", 64'(bus.adder_a_out), 64'(0));
    chk("rst_error", 64'(bus.error_out), 64'(0));
    m_idle = 1'b1;
    ptr_m = 0;
    err_m = 1'b0;
    pend_v = 1'b0;
    for (int i = 0; i < N; i++) bi[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    int exp2 [4];
    exp2 = '{0, 2, 3, 0};
    for (int i = 0; i < N; i++) regen(i);
    @(posedge clk);
    #1;
    chk("init_busy", 64'(bus.busy_out), 64'(0));
    chk("init_sum_valid", 64'(bus.sum_valid_out), 64'(0));
    chk("init_adder_rst", 64'(bus.adder_rst_out), 64'(1));
    chk("init_error", 64'(bus.error_out), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // single requester, all-ones plus one ripples a carry through every packet
    opa[1] = '1;
    opb[1] = BITS'(1);
    busy_seen = 0;
    ops_done = 0;
    owners.delete();
    req = 4'b0010;
    step();
    req = '0;
    run(6);
    chk("t1_busy_cycles", 64'(busy_seen), 64'(NP));
    chk("t1_ops", 64'(ops_done), 64'(1));
    chk("t1_owner", 64'(owners.size() == 1 ? owners[0] : -1), 64'(1));
    // three requesters held continuously from pointer 0
    do_reset();
    owners.delete();
    req = 4'b1101;
    run(20);
    req = '0;
    run(2);
    chk("t2_ops", 64'(owners.size()), 64'(4));
    for (int i = 0; i < 4 && i < owners.size(); i++) chk("t2_order", 64'(owners[i]), 64'(exp2[i]));
    // three-cycle stall mid-operation
    sums_seen = 0;
    ops_done = 0;
    req = 4'b0001;
    step();
    req = '0;
    run(2);
    hold = 3;
    run(8);
    chk("t3_beats", 64'(sums_seen), 64'(NP));
    chk("t3_ops", 64'(ops_done), 64'(1));
    // random requests and random stalls
    stall_rand = 1'b1;
    for (int i = 0; i < 200; i++) begin
      req = N'($urandom);
      step();
    end
    req = '0;
    stall_rand = 1'b0;
    wait_idle();
    // owner drops its request mid-op while another requester arrives
    owners.delete();
    req = 4'b0010;
    run(3);
    req = 4'b0100;
    run(3);
    req = '0;
    run(6);
    chk("t4_ops", 64'(owners.size()), 64'(2));
    if (owners.size() == 2) begin
      chk("t4_first", 64'(owners[0]), 64'(1));
      chk("t4_second", 64'(owners[1]), 64'(2));
    end
    // reset lands on the third beat, then a clean operation follows
    req = 4'b0001;
    step();
    req = '0;
    run(2);
    do_reset();
    ops_done = 0;
    req = 4'b0001;
    step();
    req = '0;
    run(6);
    chk("t5_ops", 64'(ops_done), 64'(1));
    // adder final flag forced on the first beat latches a sticky error
    req = 4'b0010;
    step();
    req = '0;
    force_final = 1'b1;
    step();
    force_final = 1'b0;
    run(5);
    chk("t6_error", 64'(bus.error_out), 64'(1));
    req = 4'b0100;
    step();
    req = '0;
    run(6);
    chk("t6_sticky", 64'(bus.error_out), 64'(1));
    do_reset();
    run(2);
    chk("t6_cleared", 64'(bus.error_out), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
